// File: rtl/ring_stop.sv
// ring_stop -- one stop on the token ring.
//
// Registers one slot per cycle toward the downstream stop. The outgoing slot is
// chosen by priority: messenger > locker > barrier > pass-through of the
// upstream slot. The core with tokenMaster high owns the token. It injects the
// token once after startup, then runs a watchdog that re-injects the token if
// no Token slot is seen for TOKEN_TIMEOUT cycles.
//
// Optional feature macro: RING_STOP_STATS_EN
//   defined   -> slotsDriven counts RUN cycles in which any local unit drove
//                the ring; the count wraps.
//   undefined -> slotsDriven is tied to 0.
//
// Ports
//   clock, reset            clock; asynchronous active-low reset
//   whichCore               ring ID of this core
//   tokenMaster             high on the core that originates and polices the token
//   RingIn/SlotTypeIn/SrcDestIn              slot from the upstream stop
//   {msgr,locker,barrier}{RingOut,SlotTypeOut,SrcDestOut,DriveRing}
//                           drive requests from the local units
//   RingOut/SlotTypeOut/SrcDestOut           registered slot to the downstream stop
//   ringCollision           sticky: two or more local drives in one cycle
//   tokenLost               sticky: the master watchdog expired at least once
//   slotsDriven             count of locally driven slots (see macro above)
module ring_stop #(
  parameter int INIT_DELAY    = 16,
  parameter int TOKEN_TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  whichCore,
  input  logic        tokenMaster,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SrcDestIn,
  input  logic [31:0] msgrRingOut,
  input  logic [3:0]  msgrSlotTypeOut,
  input  logic [3:0]  msgrSrcDestOut,
  input  logic        msgrDriveRing,
  input  logic [31:0] lockerRingOut,
  input  logic [3:0]  lockerSlotTypeOut,
  input  logic [3:0]  lockerSrcDestOut,
  input  logic        lockerDriveRing,
  input  logic [31:0] barrierRingOut,
  input  logic [3:0]  barrierSlotTypeOut,
  input  logic [3:0]  barrierSrcDestOut,
  input  logic        barrierDriveRing,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SrcDestOut,
  output logic        ringCollision,
  output logic        tokenLost,
  output logic [31:0] slotsDriven
);

  localparam logic [3:0] SLOT_TOKEN = 4'd1;
  localparam logic [3:0] SLOT_NULL  = 4'd7;

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_INJECT = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam int WD_W = ($clog2(TOKEN_TIMEOUT + 1) < 1) ? 1 : $clog2(TOKEN_TIMEOUT + 1);
  localparam int IC_W = ($clog2(INIT_DELAY + 1) < 1) ? 1 : $clog2(INIT_DELAY + 1);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  typ;
    logic [3:0]  sd;
  } slot_t;

  logic [1:0]      r_state;
  logic [IC_W-1:0] r_init_cnt;
  logic [WD_W-1:0] r_wd;
  slot_t           r_out;
  logic            r_coll;
  logic            r_lost;

  slot_t           w_slot;
  logic [2:0]      w_drv;
  logic            w_multi;
  logic            w_tok_seen;
  logic [WD_W-1:0] w_wd_inc;
  logic            w_wd_fire;
  logic            w_init_done;

  assign w_drv   = {msgrDriveRing, lockerDriveRing, barrierDriveRing};
  assign w_multi = (w_drv[2] & w_drv[1]) | (w_drv[2] & w_drv[0]) | (w_drv[1] & w_drv[0]);

  // Slot mux. INIT and INJECT override every local request.
  always_comb begin
    w_slot = '{data: RingIn, typ: SlotTypeIn, sd: SrcDestIn};
    if (barrierDriveRing) w_slot = '{data: barrierRingOut, typ: barrierSlotTypeOut, sd: barrierSrcDestOut};
    if (lockerDriveRing)  w_slot = '{data: lockerRingOut,  typ: lockerSlotTypeOut,  sd: lockerSrcDestOut};
    if (msgrDriveRing)    w_slot = '{data: msgrRingOut,    typ: msgrSlotTypeOut,    sd: msgrSrcDestOut};
    case (r_state)
      ST_INIT:   w_slot = '{data: 32'd0, typ: SLOT_NULL,  sd: 4'd0};
      ST_INJECT: w_slot = '{data: 32'd0, typ: SLOT_TOKEN, sd: whichCore};
      default:   ;
    endcase
  end

  // Token seen either arriving from upstream or leaving this stop.
  assign w_tok_seen  = (SlotTypeIn == SLOT_TOKEN) || (w_slot.typ == SLOT_TOKEN);
  // Saturating increment: the counter must never wrap back to 0.
  assign w_wd_inc    = (r_wd == {WD_W{1'b1}}) ? r_wd : r_wd + 1'b1;
  assign w_wd_fire   = tokenMaster && (r_state == ST_RUN) && !w_tok_seen &&
                       (32'(w_wd_inc) >= 32'(TOKEN_TIMEOUT));
  assign w_init_done = (32'(r_init_cnt) + 32'd1) >= 32'(INIT_DELAY);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (!tokenMaster) begin
            r_state <= ST_RUN;
          end else if (w_init_done) begin
            r_state    <= ST_INJECT;
            r_init_cnt <= '0;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        ST_INJECT: r_state <= ST_RUN;
        default:   if (w_wd_fire) r_state <= ST_INJECT;
      endcase
    end
  end

  // Watchdog: held at 0 except while the master is in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wd   <= '0;
      r_lost <= 1'b0;
    end else if (!tokenMaster || (r_state != ST_RUN) || w_tok_seen) begin
      r_wd <= '0;
    end else if (w_wd_fire) begin
      r_wd   <= '0;
      r_lost <= 1'b1;
    end else begin
      r_wd <= w_wd_inc;
    end
  end

  // Output register and sticky collision flag. Local drives are ignored in INIT,
  // so they cannot collide there.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out  <= '{data: 32'd0, typ: SLOT_NULL, sd: 4'd0};
      r_coll <= 1'b0;
    end else begin
      r_out <= w_slot;
      if (w_multi && (r_state != ST_INIT)) r_coll <= 1'b1;
    end
  end

`ifdef RING_STOP_STATS_EN
  logic [31:0] r_slots;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           r_slots <= '0;
    else if ((r_state == ST_RUN) && |w_drv) r_slots <= r_slots + 32'd1;
  end

  assign slotsDriven = r_slots;
`else
  assign slotsDriven = 32'd0;
`endif

  assign RingOut       = r_out.data;
  assign SlotTypeOut   = r_out.typ;
  assign SrcDestOut    = r_out.sd;
  assign ringCollision = r_coll;
  assign tokenLost     = r_lost;

endmodule

// File: tb/tb_ring_stop.sv
module tb_ring_stop;
  localparam int INIT_DELAY    = 16;
  localparam int TOKEN_TIMEOUT = 1023;

  logic        clock, reset;
  logic [3:0]  whichCore;
  logic        tokenMaster;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn, SrcDestIn;
  logic [31:0] mR, lR, bR;
  logic [3:0]  mT, mS, lT, lS, bT, bS;
  logic        mD, lD, bD;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut, SrcDestOut;
  logic        ringCollision, tokenLost;
  logic [31:0] slotsDriven;

  int n_checks = 0;
  int n_err    = 0;

  ring_stop #(.INIT_DELAY(INIT_DELAY), .TOKEN_TIMEOUT(TOKEN_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .whichCore(whichCore), .tokenMaster(tokenMaster),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SrcDestIn(SrcDestIn),
    .msgrRingOut(mR), .msgrSlotTypeOut(mT), .msgrSrcDestOut(mS), .msgrDriveRing(mD),
    .lockerRingOut(lR), .lockerSlotTypeOut(lT), .lockerSrcDestOut(lS), .lockerDriveRing(lD),
    .barrierRingOut(bR), .barrierSlotTypeOut(bT), .barrierSrcDestOut(bS), .barrierDriveRing(bD),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SrcDestOut(SrcDestOut),
    .ringCollision(ringCollision), .tokenLost(tokenLost), .slotsDriven(slotsDriven)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    RingIn = 32'd0; SlotTypeIn = 4'd7; SrcDestIn = 4'd0;
    mR = 32'd0; mT = 4'd0; mS = 4'd0; mD = 1'b0;
    lR = 32'd0; lT = 4'd0; lS = 4'd0; lD = 1'b0;
    bR = 32'd0; bT = 4'd0; bS = 4'd0; bD = 1'b0;
  endtask

  // Hold reset over two edges, then release just after a rising edge: the next
  // rising edge is edge 1 after release.
  task automatic do_reset(input logic master, input logic [3:0] core);
    reset = 1'b0; tokenMaster = master; whichCore = core;
    set_idle();
    step(); step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 4'h2);
    step();
    RingIn = 32'hDEAD_BEEF; SlotTypeIn = 4'd3; SrcDestIn = 4'd9;
    mD = 1'b1; lD = 1'b1; mR = 32'h1111; mT = 4'd4; mS = 4'd6;
    step();
    set_idle();
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({RingOut, SlotTypeOut, SrcDestOut} !== {32'd0, 4'd7, 4'd0}) begin
      n_err++; $display("FAIL reset_slot: got %h/%0d/%0d want 0/7/0", RingOut, SlotTypeOut, SrcDestOut);
    end
    n_checks++;
    if ({ringCollision, tokenLost, slotsDriven} !== 34'd0) begin
      n_err++; $display("FAIL reset_flags: got coll=%0b lost=%0b slots=%0d want 0/0/0", ringCollision, tokenLost, slotsDriven);
    end
  endtask

  task automatic test_master_startup();
    int ntok;
    logic [39:0] exp;
    do_reset(1'b1, 4'hA);
    // Noise and colliding drives during INIT must be suppressed.
    RingIn = 32'hABCD; SlotTypeIn = 4'd13; SrcDestIn = 4'd3;
    mD = 1'b1; mR = 32'h5555; mT = 4'd2; mS = 4'd1;
    lD = 1'b1; lR = 32'h6666; lT = 4'd5; lS = 4'd2;
    ntok = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == INIT_DELAY - 1) set_idle();
      exp = (k == INIT_DELAY + 1) ? {32'd0, 4'd1, 4'hA} : {32'd0, 4'd7, 4'd0};
      if (SlotTypeOut == 4'd1) ntok++;
      n_checks++;
      if ({RingOut, SlotTypeOut, SrcDestOut} !== exp) begin
        n_err++; $display("FAIL startup_slot edge %0d: got %h/%0d/%0d want %h/%0d/%0d", k,
                          RingOut, SlotTypeOut, SrcDestOut, exp[39:8], exp[7:4], exp[3:0]);
      end
    end
    n_checks++;
    if (ntok != 1) begin
      n_err++; $display("FAIL startup_token_count: got %0d want 1", ntok);
    end
    n_checks++;
    if ({ringCollision, slotsDriven} !== 33'd0) begin
      n_err++; $display("FAIL startup_init_drives: got coll=%0b slots=%0d want 0/0", ringCollision, slotsDriven);
    end
  endtask

  task automatic test_passthrough();
    do_reset(1'b0, 4'h4);
    step();
    RingIn = 32'h1234; SlotTypeIn = 4'd13; SrcDestIn = 4'd5;
    #1;
    n_checks++;
    if (SlotTypeOut !== 4'd7) begin
      n_err++; $display("FAIL pass_latency: got type %0d before edge want 7", SlotTypeOut);
    end
    step();
    n_checks++;
    if ({RingOut, SlotTypeOut, SrcDestOut} !== {32'h1234, 4'd13, 4'd5}) begin
      n_err++; $display("FAIL pass_slot: got %h/%0d/%0d want 1234/13/5", RingOut, SlotTypeOut, SrcDestOut);
    end
  endtask

  task automatic test_collision();
    do_reset(1'b0, 4'h5);
    step();
    step();
    n_checks++;
    if (ringCollision !== 1'b0) begin
      n_err++; $display("FAIL coll_idle: got %0b want 0", ringCollision);
    end
    mD = 1'b1; mR = 32'hCAFE_0001; mT = 4'd2; mS = 4'd8;
    bD = 1'b1; bR = 32'hB00B_0002; bT = 4'd13; bS = 4'd9;
    step();
    set_idle();
    n_checks++;
    if ({RingOut, SlotTypeOut, SrcDestOut} !== {32'hCAFE_0001, 4'd2, 4'd8}) begin
      n_err++; $display("FAIL coll_winner: got %h/%0d/%0d want cafe0001/2/8", RingOut, SlotTypeOut, SrcDestOut);
    end
    n_checks++;
    if (ringCollision !== 1'b1) begin
      n_err++; $display("FAIL coll_flag: got %0b want 1", ringCollision);
    end
    repeat (5) step();
    n_checks++;
    if (ringCollision !== 1'b1) begin
      n_err++; $display("FAIL coll_sticky: got %0b want 1", ringCollision);
    end
  endtask

  task automatic test_random();
    logic [39:0] exp;
    logic ec;
    int es, nd;
    do_reset(1'b0, 4'h3);
    step();
    ec = 1'b0; es = 0;
    for (int i = 0; i < 300; i++) begin
      RingIn = $urandom; SlotTypeIn = 4'($urandom_range(0, 15)); SrcDestIn = 4'($urandom_range(0, 15));
      mR = $urandom; mT = 4'($urandom_range(0, 15)); mS = 4'($urandom_range(0, 15));
      lR = $urandom; lT = 4'($urandom_range(0, 15)); lS = 4'($urandom_range(0, 15));
      bR = $urandom; bT = 4'($urandom_range(0, 15)); bS = 4'($urandom_range(0, 15));
      mD = ($urandom_range(0, 3) == 0); lD = ($urandom_range(0, 3) == 0); bD = ($urandom_range(0, 3) == 0);
      if (mD)      exp = {mR, mT, mS};
      else if (lD) exp = {lR, lT, lS};
      else if (bD) exp = {bR, bT, bS};
      else         exp = {RingIn, SlotTypeIn, SrcDestIn};
      nd = int'(mD) + int'(lD) + int'(bD);
      if (nd >= 2) ec = 1'b1;
      if (nd >= 1) es++;
      step();
      n_checks++;
      if ({RingOut, SlotTypeOut, SrcDestOut} !== exp) begin
        n_err++; $display("FAIL rand_slot cycle %0d: got %h want %h", i, {RingOut, SlotTypeOut, SrcDestOut}, exp);
      end
      n_checks++;
      if (ringCollision !== ec) begin
        n_err++; $display("FAIL rand_coll cycle %0d: got %0b want %0b", i, ringCollision, ec);
      end
    end
    set_idle();
`ifndef RING_STOP_STATS_EN
    es = 0;
`endif
    n_checks++;
    if (slotsDriven !== 32'(es)) begin
      n_err++; $display("FAIL rand_slots: got %0d want %0d", slotsDriven, es);
    end
    n_checks++;
    if (tokenLost !== 1'b0) begin
      n_err++; $display("FAIL rand_nonmaster_lost: got %0b want 0", tokenLost);
    end
  endtask

  task automatic test_watchdog();
    int lost_at, tok1, tok2, ntok;
    do_reset(1'b1, 4'hC);
    lost_at = -1; tok1 = -1; tok2 = -1; ntok = 0;
    for (int k = 1; k <= 1100; k++) begin
      step();
      if (tokenLost && lost_at < 0) lost_at = k;
      if (SlotTypeOut == 4'd1) begin
        ntok++;
        if (tok1 < 0) tok1 = k; else if (tok2 < 0) tok2 = k;
      end
    end
    n_checks++;
    if (lost_at != INIT_DELAY + TOKEN_TIMEOUT + 1) begin
      n_err++; $display("FAIL wd_lost_edge: got %0d want %0d", lost_at, INIT_DELAY + TOKEN_TIMEOUT + 1);
    end
    n_checks++;
    if (tok2 != INIT_DELAY + TOKEN_TIMEOUT + 2) begin
      n_err++; $display("FAIL wd_reinject_edge: got %0d want %0d", tok2, INIT_DELAY + TOKEN_TIMEOUT + 2);
    end
    n_checks++;
    if (ntok != 2 || tok1 != INIT_DELAY + 1) begin
      n_err++; $display("FAIL wd_token_count: got %0d first %0d want 2 first %0d", ntok, tok1, INIT_DELAY + 1);
    end
  endtask

  task automatic test_watchdog_fed();
    do_reset(1'b1, 4'h6);
    for (int k = 1; k <= 2200; k++) begin
      SlotTypeIn = (k % 700 == 0) ? 4'd1 : 4'd7;
      step();
    end
    set_idle();
    n_checks++;
    if (tokenLost !== 1'b0) begin
      n_err++; $display("FAIL wd_fed_lost: got %0b want 0", tokenLost);
    end
  endtask

  task automatic test_reset_inject();
    int ntok, first;
    do_reset(1'b1, 4'h9);
    repeat (INIT_DELAY) step();
    // Master is now in its INJECT cycle; abort it.
    reset = 1'b0;
    #1;
    n_checks++;
    if ({RingOut, SlotTypeOut, SrcDestOut} !== {32'd0, 4'd7, 4'd0}) begin
      n_err++; $display("FAIL inj_reset_now: got %h/%0d/%0d want 0/7/0", RingOut, SlotTypeOut, SrcDestOut);
    end
    step();
    n_checks++;
    if (SlotTypeOut !== 4'd7) begin
      n_err++; $display("FAIL inj_reset_hold: got type %0d want 7", SlotTypeOut);
    end
    step();
    reset = 1'b1;
    ntok = 0; first = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (SlotTypeOut == 4'd1) begin
        ntok++;
        if (first < 0) first = k;
      end
    end
    n_checks++;
    if (ntok != 1 || first != INIT_DELAY + 1) begin
      n_err++; $display("FAIL inj_reset_token: got count %0d at %0d want 1 at %0d", ntok, first, INIT_DELAY + 1);
    end
  endtask

  task automatic test_stats();
    int exp;
    do_reset(1'b0, 4'h7);
    mD = 1'b1; mR = 32'h77; mT = 4'd2; mS = 4'd1;
    step();
    for (int i = 0; i < 10; i++) begin
      mD = (i % 2 == 0);
      step();
    end
    set_idle();
    step();
`ifdef RING_STOP_STATS_EN
    exp = 5;
`else
    exp = 0;
`endif
    n_checks++;
    if (slotsDriven !== 32'(exp)) begin
      n_err++; $display("FAIL stats_count: got %0d want %0d", slotsDriven, exp);
    end
  endtask

  initial begin
    reset = 1'b0; tokenMaster = 1'b0; whichCore = 4'd0;
    set_idle();
    test_reset();
    test_master_startup();
    test_passthrough();
    test_collision();
    test_random();
    test_watchdog();
    test_watchdog_fed();
    test_reset_inject();
    test_stats();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/ring_stop.md
RING_STOP -- requirements
Module: ring_stop

Interface
REQ-001 Parameter INIT_DELAY, default 16: cycles the token master waits after reset release before injecting the token.
REQ-002 Parameter TOKEN_TIMEOUT, default 1023: maximum cycles the token master tolerates without seeing a Token slot.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 whichCore  input  4  this core's ring ID.
REQ-006 tokenMaster  input  1  high on exactly one core: that core originates and polices the token; static after reset.
REQ-007 RingIn, SlotTypeIn, SrcDestIn  input  32/4/4  slot arriving from the upstream stop; also fanned out unmodified to the local units.
REQ-008 msgrRingOut, msgrSlotTypeOut, msgrSrcDestOut, msgrDriveRing  input  32/4/4/1  messenger drive request.
REQ-009 lockerRingOut, lockerSlotTypeOut, lockerSrcDestOut, lockerDriveRing  input  32/4/4/1  locker drive request.
REQ-010 barrierRingOut, barrierSlotTypeOut, barrierSrcDestOut, barrierDriveRing  input  32/4/4/1  barrier unit drive request.
REQ-011 RingOut, SlotTypeOut, SrcDestOut  output  32/4/4  registered slot sent to the downstream stop.
REQ-012 ringCollision  output  1  sticky: two or more local units drove in the same cycle.
REQ-013 tokenLost  output  1  sticky: the master's watchdog expired at least once.
REQ-014 slotsDriven  output  32  count of slots driven locally (see Configuration).

Function
REQ-015 Slot type codes are Token=1, Null=7 and Barrier=13; all other codes pass through opaquely.
REQ-016 Output slot is registered: the value presented in cycle N appears on RingOut/SlotTypeOut/SrcDestOut in cycle N+1; latency is exactly 1.
REQ-017 Mux priority: messenger > locker > barrier > pass-through of RingIn/SlotTypeIn/SrcDestIn.
REQ-018 If two or more DriveRing inputs are high in one cycle, the stop sets ringCollision and the highest-priority requester still wins.
REQ-019 FSM states: INIT, INJECT, RUN.
REQ-020 Reset enters INIT; a non-master core moves INIT->RUN on the first cycle after reset release.
REQ-021 The master stays in INIT for INIT_DELAY cycles, then enters INJECT.
REQ-022 INJECT lasts 1 cycle and overrides the mux: SlotType=Token, RingIn=0 (train length 0), SrcDest=whichCore; the next state is RUN.
REQ-023 In INIT, every slot is forced to Null with data 0 and local drives are ignored.
REQ-024 Master watchdog in RUN: the counter clears on any cycle where SlotTypeIn==Token or this stop forwards a Token; otherwise it increments.
REQ-025 When the watchdog counter reaches TOKEN_TIMEOUT, the stop sets tokenLost, clears the counter and returns to INJECT (token re-injected).
REQ-026 On a non-master core the watchdog is held at 0 and tokenLost stays 0.
REQ-027 The watchdog counter width is clog2(TOKEN_TIMEOUT+1) and it saturates; it never wraps.

Reset
REQ-028 Asserting reset asynchronously drives SlotTypeOut=7 (Null), RingOut=0, SrcDestOut=0, ringCollision=0, tokenLost=0, slotsDriven=0, FSM=INIT and the watchdog to 0.
REQ-029 Reset asserted mid-operation discards any in-flight slot, including an INJECT in progress; after release the startup sequence repeats from INIT.

Configuration
REQ-030 Macro RING_STOP_STATS_EN.
- Defined: slotsDriven increments by 1 in each RUN cycle in which any DriveRing is high, wrapping from 0xFFFFFFFF to 0.
- Undefined: slotsDriven is constant 0 and no counter is synthesized.

Verification
REQ-031 Master, INIT_DELAY=16: release reset -> Null slots are output until the Token (SlotTypeOut=1, RingOut=0, SrcDestOut=whichCore) appears exactly once, INIT_DELAY+1 cycles after release.
REQ-032 RUN, no drives, SlotTypeIn=13, RingIn=0x1234, SrcDestIn=5 -> the same values appear on the outputs one cycle later.
REQ-033 msgrDriveRing and barrierDriveRing high together -> the messenger slot is output and ringCollision=1, remaining 1 until reset.
REQ-034 Master, TOKEN_TIMEOUT=1023, no Token on SlotTypeIn -> after 1023 RUN cycles tokenLost=1 and a fresh Token is output.
REQ-035 Reset asserted during INJECT -> outputs go to Null/0 immediately and only one Token follows INIT_DELAY+1 cycles after release.
REQ-036 RING_STOP_STATS_EN defined, 5 driven cycles -> slotsDriven=5; with the macro undefined, slotsDriven=0.
